// File: rtl/axi4_lite_slave_regs.sv
// axi4_lite_slave_regs
//   AXI4-Lite slave register bank: NUM_REGS x 32-bit read/write registers
//   with byte strobes. Out-of-range accesses (addr >= 4*NUM_REGS) return
//   SLVERR; writes to them change nothing, and reads of them return 0.
//   Independent write and read state machines, each with at most one
//   transaction outstanding. All handshake outputs come straight from flops.
// Ports
//   ACLK, ARESETN           clock (rising edge), async active-low reset
//   S_AW*/S_W*/S_B*         write address / data / response channels
//   S_AR*/S_R*              read address / data channels
// Submodule axi4_lite_reg_slot: one byte-strobed register, one instance
// per register index.

module axi4_lite_reg_slot #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_W     = DATA_WIDTH / 8
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  we,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] q
);
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      q <= '0;
    end else if (we) begin
      for (int b = 0; b < STRB_W; b++)
        if (wstrb[b]) q[8*b +: 8] <= wdata[8*b +: 8];
    end
  end
endmodule

module axi4_lite_slave_regs #(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic [ADDRESS-1:0]    S_AWADDR,
  input  logic                  S_AWVALID,
  output logic                  S_AWREADY,
  input  logic [DATA_WIDTH-1:0] S_WDATA,
  input  logic [3:0]            S_WSTRB,
  input  logic                  S_WVALID,
  output logic                  S_WREADY,
  output logic [1:0]            S_BRESP,
  output logic                  S_BVALID,
  input  logic                  S_BREADY,
  input  logic [ADDRESS-1:0]    S_ARADDR,
  input  logic                  S_ARVALID,
  output logic                  S_ARREADY,
  output logic [DATA_WIDTH-1:0] S_RDATA,
  output logic [1:0]            S_RRESP,
  output logic                  S_RVALID,
  input  logic                  S_RREADY
);
  localparam int               IDX_W      = $clog2(NUM_REGS);
  localparam logic [ADDRESS-1:0] ADDR_LIMIT = ADDRESS'(4 * NUM_REGS);
  localparam logic [1:0]       RESP_OKAY  = 2'b00;
  localparam logic [1:0]       RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_REGS-1:0]                 reg_we;

  // Address decode; addr[1:0] is ignored, range check uses the full address.
  logic             wr_oor, rd_oor;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  assign wr_oor = (S_AWADDR >= ADDR_LIMIT);
  assign rd_oor = (S_ARADDR >= ADDR_LIMIT);
  assign wr_idx = S_AWADDR[2 +: IDX_W];
  assign rd_idx = S_ARADDR[2 +: IDX_W];

  // Register array: write strobe decoded per slot, commit at the W_ACK edge.
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    assign reg_we[k] = (w_state == W_ACK) && !wr_oor && (wr_idx == IDX_W'(k));
    axi4_lite_reg_slot #(.DATA_WIDTH(DATA_WIDTH), .STRB_W(4)) u_slot (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .we      (reg_we[k]),
      .wstrb   (S_WSTRB),
      .wdata   (S_WDATA),
      .q       (regs[k])
    );
  end

  // ---------------- write channel ----------------
  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (S_AWVALID && S_WVALID) w_next = W_ACK;
      W_ACK:   w_next = W_RESP;
      W_RESP:  if (S_BREADY) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // Readies/valid are registered from the next state so they toggle
  // cleanly and AWREADY/WREADY always move together.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state   <= W_IDLE;
      S_AWREADY <= 1'b0;
      S_WREADY  <= 1'b0;
      S_BVALID  <= 1'b0;
      S_BRESP   <= RESP_OKAY;
    end else begin
      w_state   <= w_next;
      S_AWREADY <= (w_next == W_ACK);
      S_WREADY  <= (w_next == W_ACK);
      S_BVALID  <= (w_next == W_RESP);
      if (w_state == W_ACK) S_BRESP <= wr_oor ? RESP_SLVERR : RESP_OKAY;
    end
  end

  // ---------------- read channel ----------------
  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (S_ARVALID) r_next = R_ACK;
      R_ACK:   r_next = R_DATA;
      R_DATA:  if (S_RREADY) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // RDATA samples regs before this edge's write lands, so a write and read
  // acknowledged on the same edge to one register return the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state   <= R_IDLE;
      S_ARREADY <= 1'b0;
      S_RVALID  <= 1'b0;
      S_RDATA   <= '0;
      S_RRESP   <= RESP_OKAY;
    end else begin
      r_state   <= r_next;
      S_ARREADY <= (r_next == R_ACK);
      S_RVALID  <= (r_next == R_DATA);
      if (r_state == R_ACK) begin
        S_RDATA <= rd_oor ? '0 : regs[rd_idx];
        S_RRESP <= rd_oor ? RESP_SLVERR : RESP_OKAY;
      end else if (r_state == R_DATA && S_RREADY) begin
        S_RDATA <= '0;
      end
    end
  end
endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Bench for axi4_lite_slave_regs: directed scenarios with literal expectations
// plus concurrent randomized write/read traffic, all checked every cycle
// against a transaction-level model (register array + expected channel phase).

module tb_axi4_lite_slave_regs;
  localparam int NREG = 16;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [31:0] S_AWADDR = '0;
  logic        S_AWVALID = 1'b0;
  logic        S_AWREADY;
  logic [31:0] S_WDATA = '0;
  logic [3:0]  S_WSTRB = '0;
  logic        S_WVALID = 1'b0;
  logic        S_WREADY;
  logic [1:0]  S_BRESP;
  logic        S_BVALID;
  logic        S_BREADY = 1'b0;
  logic [31:0] S_ARADDR = '0;
  logic        S_ARVALID = 1'b0;
  logic        S_ARREADY;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RVALID;
  logic        S_RREADY = 1'b0;

  axi4_lite_slave_regs #(.ADDRESS(32), .DATA_WIDTH(32), .NUM_REGS(NREG)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
    .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
    .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  always #5 ACLK = ~ACLK;

  int n_chk = 0;
  int n_fail = 0;
  bit hold_b = 1'b0;
  bit hold_r = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] mem [NREG];
  bit          e_aw, e_bv, e_ar, e_rv;
  logic [1:0]  e_br, e_rr;
  logic [31:0] e_rd;

  function automatic bit out_of_range(input logic [31:0] a);
    return a >= 32'(4 * NREG);
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a / 4) % NREG);
  endfunction

  // Each negedge: compare DUT outputs with the expected phase of each
  // channel, then advance the model using this cycle's inputs.
  initial begin
    forever begin
      @(negedge ACLK);
      if (!ARESETN) begin
        chk("rst_awready", 32'(S_AWREADY), 0);
        chk("rst_wready",  32'(S_WREADY), 0);
        chk("rst_bvalid",  32'(S_BVALID), 0);
        chk("rst_bresp",   32'(S_BRESP), 0);
        chk("rst_arready", 32'(S_ARREADY), 0);
        chk("rst_rvalid",  32'(S_RVALID), 0);
        chk("rst_rresp",   32'(S_RRESP), 0);
        chk("rst_rdata",   S_RDATA, 0);
        for (int i = 0; i < NREG; i++) mem[i] = '0;
        e_aw = 0; e_bv = 0; e_ar = 0; e_rv = 0;
      end else begin
        chk("awready", 32'(S_AWREADY), 32'(e_aw));
        chk("wready",  32'(S_WREADY),  32'(e_aw));
        chk("bvalid",  32'(S_BVALID),  32'(e_bv));
        if (e_bv) chk("bresp", 32'(S_BRESP), 32'(e_br));
        chk("arready", 32'(S_ARREADY), 32'(e_ar));
        chk("rvalid",  32'(S_RVALID),  32'(e_rv));
        if (e_rv) begin
          chk("rdata", S_RDATA, e_rd);
          chk("rresp", 32'(S_RRESP), 32'(e_rr));
        end else begin
          chk("rdata_idle", S_RDATA, 0);
        end
        // Read resolves first: a write accepted on the same edge is not seen.
        if (e_ar) begin
          e_rd = out_of_range(S_ARADDR) ? 32'h0 : mem[idx_of(S_ARADDR)];
          e_rr = out_of_range(S_ARADDR) ? 2'b10 : 2'b00;
          e_ar = 0; e_rv = 1;
        end else if (e_rv) begin
          if (S_RREADY) e_rv = 0;
        end else begin
          e_ar = S_ARVALID;
        end
        if (e_aw) begin
          if (!out_of_range(S_AWADDR))
            for (int b = 0; b < 4; b++)
              if (S_WSTRB[b]) mem[idx_of(S_AWADDR)][8*b +: 8] = S_WDATA[8*b +: 8];
          e_br = out_of_range(S_AWADDR) ? 2'b10 : 2'b00;
          e_aw = 0; e_bv = 1;
        end else if (e_bv) begin
          if (S_BREADY) e_bv = 0;
        end else begin
          e_aw = S_AWVALID && S_WVALID;
        end
      end
    end
  end

  // Random response backpressure unless a directed test pins it low.
  initial begin
    forever begin
      @(posedge ACLK);
      #1;
      S_BREADY = hold_b ? 1'b0 : ($urandom_range(0, 3) != 0);
      S_RREADY = hold_r ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- bus tasks ----------------
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int split, output logic [1:0] resp, output int lat);
    int n;
    @(posedge ACLK); #1;
    S_AWADDR = a; S_WDATA = d; S_WSTRB = s;
    S_AWVALID = 1'b1; S_WVALID = (split == 0);
    if (split > 0) begin
      repeat (split) @(posedge ACLK);
      #1 S_WVALID = 1'b1;
    end
    lat = 0;
    do begin @(negedge ACLK); lat++; end while (!S_AWREADY && lat < 20);
    chk("aw_handshake", 32'(S_AWREADY), 1);
    @(posedge ACLK); #1;
    S_AWVALID = 1'b0; S_WVALID = 1'b0; S_WDATA = $urandom;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!(S_BVALID && S_BREADY) && n < 200);
    chk("b_handshake", 32'(S_BVALID && S_BREADY), 1);
    resp = S_BRESP;
    @(posedge ACLK);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] data,
                         output logic [1:0] resp, output int lat);
    int n;
    @(posedge ACLK); #1;
    S_ARADDR = a; S_ARVALID = 1'b1;
    lat = 0;
    do begin @(negedge ACLK); lat++; end while (!S_ARREADY && lat < 20);
    chk("ar_handshake", 32'(S_ARREADY), 1);
    @(posedge ACLK); #1;
    S_ARVALID = 1'b0;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!(S_RVALID && S_RREADY) && n < 200);
    chk("r_handshake", 32'(S_RVALID && S_RREADY), 1);
    data = S_RDATA; resp = S_RRESP;
    @(posedge ACLK);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned sel = $urandom_range(0, 7);
    logic [31:0] low = 32'($urandom_range(0, 3));
    if (sel == 0) return 32'(4 * NREG) + 32'($urandom_range(0, 15) * 4) + low;
    if (sel == 1) return $urandom | 32'h0000_1000;
    if (sel < 5)  return 32'($urandom_range(0, 1) * 4) + low;
    return 32'($urandom_range(0, NREG - 1) * 4) + low;
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [1:0]  r;
    logic [31:0] d;
    int          l;
    int          n;

    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;

    // T1 write then read
    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, r, l);
    chk("t1_bresp", 32'(r), 0);
    chk("t1_w_latency", 32'(l), 2);
    do_read(32'h4, d, r, l);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", 32'(r), 0);
    chk("t1_r_latency", 32'(l), 2);

    // T2 byte strobes
    do_write(32'h8, 32'h11223344, 4'hF, 0, r, l);
    do_write(32'h8, 32'hAABBCCDD, 4'b0101, 0, r, l);
    do_read(32'h8, d, r, l);
    chk("t2_rdata", d, 32'h11BB33DD);

    // T3 out of range
    do_write(32'h40, 32'h5, 4'hF, 0, r, l);
    chk("t3_bresp", 32'(r), 2);
    do_read(32'h40, d, r, l);
    chk("t3_rdata", d, 0);
    chk("t3_rresp", 32'(r), 2);
    do_read(32'h4, d, r, l);
    chk("t3_reg4_kept", d, 32'hDEADBEEF);
    do_read(32'h0, d, r, l);
    chk("t3_reg0_kept", d, 0);

    // T4 backpressure on B, with a second AW/W offered while pending
    hold_b = 1'b1;
    fork
      do_write(32'hC, 32'hCAFEF00D, 4'hF, 0, r, l);
      begin
        n = 0;
        do begin @(negedge ACLK); n++; end while (!S_BVALID && n < 20);
        @(posedge ACLK); #1;
        S_AWADDR = 32'h10; S_WVALID = 1'b1; S_AWVALID = 1'b1;
        repeat (5) begin
          @(negedge ACLK);
          chk("t4_bvalid_hold", 32'(S_BVALID), 1);
          chk("t4_no_awready", 32'(S_AWREADY), 0);
        end
        @(posedge ACLK); #1;
        S_AWVALID = 1'b0; S_WVALID = 1'b0;
        hold_b = 1'b0;
      end
    join
    chk("t4_bresp", 32'(r), 0);

    // T4 backpressure on R, with a second AR offered while pending
    hold_r = 1'b1;
    fork
      do_read(32'hC, d, r, l);
      begin
        n = 0;
        do begin @(negedge ACLK); n++; end while (!S_RVALID && n < 20);
        @(posedge ACLK); #1;
        S_ARADDR = 32'h8; S_ARVALID = 1'b1;
        repeat (5) begin
          @(negedge ACLK);
          chk("t4_rvalid_hold", 32'(S_RVALID), 1);
          chk("t4_rdata_hold", S_RDATA, 32'hCAFEF00D);
          chk("t4_no_arready", 32'(S_ARREADY), 0);
        end
        @(posedge ACLK); #1;
        S_ARVALID = 1'b0;
        hold_r = 1'b0;
      end
    join
    chk("t4_rdata", d, 32'hCAFEF00D);

    // T5 AW without W for 4 cycles
    do_write(32'h14, 32'h0BADC0DE, 4'hF, 4, r, l);
    chk("t5_latency_after_w", 32'(l), 2);
    do_read(32'h14, d, r, l);
    chk("t5_rdata", d, 32'h0BADC0DE);

    // Concurrent randomized traffic
    fork
      begin
        logic [1:0] wr;
        int         wl;
        for (int i = 0; i < 150; i++) begin
          do_write(rand_addr(), $urandom, 4'($urandom_range(0, 15)),
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0, wr, wl);
          chk("rnd_w_latency", 32'(wl), 2);
          repeat ($urandom_range(0, 2)) @(posedge ACLK);
        end
      end
      begin
        logic [31:0] rd;
        logic [1:0]  rr;
        int          rl;
        for (int i = 0; i < 150; i++) begin
          do_read(rand_addr(), rd, rr, rl);
          chk("rnd_r_latency", 32'(rl), 2);
          repeat ($urandom_range(0, 2)) @(posedge ACLK);
        end
      end
    join

    // T6 reset while BVALID pending
    hold_b = 1'b1;
    @(posedge ACLK); #1;
    S_AWADDR = 32'h0; S_WDATA = 32'hFF; S_WSTRB = 4'hF;
    S_AWVALID = 1'b1; S_WVALID = 1'b1;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_AWREADY && n < 20);
    @(posedge ACLK); #1;
    S_AWVALID = 1'b0; S_WVALID = 1'b0;
    n = 0;
    do begin @(negedge ACLK); n++; end while (!S_BVALID && n < 20);
    chk("t6_bvalid_before_reset", 32'(S_BVALID), 1);
    #2 ARESETN = 1'b0;
    #1;
    chk("t6_awready", 32'(S_AWREADY), 0);
    chk("t6_bvalid", 32'(S_BVALID), 0);
    chk("t6_bresp", 32'(S_BRESP), 0);
    chk("t6_rdata", S_RDATA, 0);
    hold_b = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    repeat (3) @(negedge ACLK);
    chk("t6_no_late_bvalid", 32'(S_BVALID), 0);
    do_read(32'h0, d, r, l);
    chk("t6_reg0_cleared", d, 0);
    chk("t6_rresp", 32'(r), 0);

    repeat (4) @(posedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
